alu_exec_controller: RTL and testbench
======================================

Name: alu_exec_controller

Overview:
- Parametrised successor of the single-cycle ALU operation decoder.
- Decodes func_7/func_3/alu_option into the 4-bit ALU operation code, now with shifts and full branch compares.
- Adds an RV32M-style iterative multiply/divide sequencer with a valid/ready handshake and a pipeline stall output.
- Sits between main control/register read and the ALU/writeback mux in the execute stage.

Parameters:
- XLEN, 32: operand and result width; must be a power of two, at least 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, not overridden.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- func_7_bits  in  7  instruction funct7
- func_3_bits  in  3  instruction funct3
- alu_option  in  4  instruction class from main control
- in_valid  in  1  instruction in execute is valid
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value
- flush  in  1  synchronous abort of any M-op in flight
- out_ready  in  1  writeback accepts md_result
- alu_operation  out  4  ALU op code, combinational
- alu_shift_arith  out  1  1 = arithmetic right shift, combinational
- in_ready  out  1  sequencer idle
- stall  out  1  hold upstream pipeline
- out_valid  out  1  md_result valid
- md_result  out  XLEN  multiply/divide result

Behaviour:
- Op codes: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, U_LOW_EQ=0101, S_LOW_EQ=0110, U_HIGH_EQ=0111, S_HIGH_EQ=1000, U_LOWER=1001, S_LOWER=1010, U_HIGHER=1011, S_HIGHER=1100, SHIFT_LEFT=1101, SHIFT_RIGHT=1110, MULDIV=1111.
- Decode is purely combinational and does not depend on in_valid.
- alu_option 0010, by funct3:
  - 000 ADD, 001 SHIFT_LEFT, 010 S_LOWER, 011 U_LOWER.
  - 100 XOR, 101 SHIFT_RIGHT, 110 OR, 111 AND.
- alu_option 0110:
  - funct7=0000001: MULDIV.
  - Otherwise same funct3 table as 0010, except funct7[5]=1 with funct3 000 gives SUB.
- alu_shift_arith = funct7[5] when the decoded op is SHIFT_RIGHT, else 0.
- alu_option 1100, by funct3: 000 SUB, 001 XOR, 100 S_LOWER, 101 S_HIGH_EQ, 110 U_LOWER, 111 U_HIGH_EQ; other funct3 ADD.
- All other alu_option values (0000, 0011, 0100, 0111, undefined): ADD.
- Sequencer states: IDLE, CALC, DONE.
- Accept: IDLE and in_valid and alu_option=0110 and funct7=0000001 and !flush.
  - Latch operand_a, operand_b, funct3 and signs; counter = XLEN.
- Ops by funct3: 000 MUL (low word), 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply: radix-2 shift-add on magnitudes, XLEN CALC cycles; sign corrected in DONE entry.
- Divide: restoring, XLEN CALC cycles. Quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
- Fast path, IDLE -> DONE directly (latency 1):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give operand_a.
  - Signed MIN / -1: DIV gives MIN; REM gives 0.
- Normal latency: accept at cycle 0, out_valid high at cycle XLEN+1.
- out_valid = (state==DONE). md_result is held stable until out_ready.
- DONE and out_ready: return to IDLE; no back-to-back accept in that same cycle.
- in_ready = (state==IDLE).
- stall = (IDLE and accept condition) or CALC or (DONE and !out_ready).
- flush: any state -> IDLE next cycle. out_valid is low and stall is 0 in the flush cycle. No accept while flush is high.
- Reset: state IDLE, counter 0, md_result 0, out_valid 0, stall 0, in_ready 1. Reset mid-CALC discards the op.

Optional Feature:
- Macro: ALU_EXEC_MULDIV_EN.
- Defined: full sequencer as above.
- Undefined:
  - funct7=0000001 decodes per the normal funct3 table, treated as funct7[5]=0.
  - No sequencer: in_ready=1, stall=0, out_valid=0, md_result=0.

Test Plan:
1. Decode sweep: 0110/0100000/000 -> SUB; 0010/0100000/101 -> SHIFT_RIGHT with arith=1; 1100/111 -> U_HIGH_EQ; 1111 -> ADD.
2. MUL 7 x 0xFFFFFFFD -> stall high 33 cycles, out_valid at cycle 33, md_result 0xFFFFFFEB.
3. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000.
4. DIV 100 / 0 -> out_valid at cycle 1, 0xFFFFFFFF. REM 100 / 0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0.
5. DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. out_ready low 5 cycles -> result held and stall high throughout.
6. flush at CALC cycle 10 -> IDLE next cycle, out_valid never asserts. rst_n low mid-CALC -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/alu_exec_controller.sv
// alu_exec_controller: execute-stage ALU op decoder with an optional iterative multiply/divide sequencer.
// Define ALU_EXEC_MULDIV_EN to build the sequencer; otherwise funct7=0000001 decodes as a plain R-type op.
module alu_exec_controller #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      func_7_bits,
  input  logic [2:0]      func_3_bits,
  input  logic [3:0]      alu_option,
  input  logic            in_valid,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  input  logic            out_ready,
  output logic [3:0]      alu_operation,
  output logic            alu_shift_arith,
  output logic            in_ready,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] md_result
);
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100, OP_S_HIGH_EQ = 4'b1000, OP_U_LOWER = 4'b1001;
  localparam logic [3:0] OP_S_LOWER = 4'b1010, OP_U_HIGH_EQ = 4'b0111, OP_SLL = 4'b1101;
  localparam logic [3:0] OP_SRL = 4'b1110, OP_MULDIV = 4'b1111;
  logic [3:0] r_op, b_op;
  logic       md_dec;
  always_comb begin
    case (func_3_bits)
      3'b000:  r_op = OP_ADD;
      3'b001:  r_op = OP_SLL;
      3'b010:  r_op = OP_S_LOWER;
      3'b011:  r_op = OP_U_LOWER;
      3'b100:  r_op = OP_XOR;
      3'b101:  r_op = OP_SRL;
      3'b110:  r_op = OP_OR;
      default: r_op = OP_AND;
    endcase
    case (func_3_bits)
      3'b000:  b_op = OP_SUB;
      3'b001:  b_op = OP_XOR;
      3'b100:  b_op = OP_S_LOWER;
      3'b101:  b_op = OP_S_HIGH_EQ;
      3'b110:  b_op = OP_U_LOWER;
      3'b111:  b_op = OP_U_HIGH_EQ;
      default: b_op = OP_ADD;
    endcase
  end
  always_comb begin
    alu_operation = OP_ADD;
    if (alu_option == 4'b0010)
      alu_operation = r_op;
    else if (alu_option == 4'b0110)
      alu_operation = md_dec ? OP_MULDIV : (func_7_bits[5] && func_3_bits == 3'b000) ? OP_SUB : r_op;
    else if (alu_option == 4'b1100)
      alu_operation = b_op;
  end
  assign alu_shift_arith = (alu_operation == OP_SRL) && func_7_bits[5];
`ifdef ALU_EXEC_MULDIV_EN
  localparam logic [1:0] S_IDLE = 2'b00, S_CALC = 2'b01, S_DONE = 2'b10;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic              sign_a, sign_b, sa, sb, accept, div_zero, div_ovf, neg_p;
  logic [XLEN-1:0]   acc, lo, div_b, mag_a, mag_b, nxt_acc, nxt_lo, quo, rem, fin, fast;
  logic [XLEN:0]     sum, trial;
  logic [2*XLEN-1:0] prod, sprod;
  assign md_dec   = func_7_bits == 7'b0000001;
  assign accept   = state == S_IDLE && in_valid && alu_option == 4'b0110 && md_dec && !flush;
  assign sa       = operand_a[XLEN-1] && (func_3_bits[2] ? !func_3_bits[0] : func_3_bits[1:0] != 2'b11);
  assign sb       = operand_b[XLEN-1] && (func_3_bits[2] ? !func_3_bits[0] : !func_3_bits[1]);
  assign mag_a    = sa ? -operand_a : operand_a;
  assign mag_b    = sb ? -operand_b : operand_b;
  assign div_zero = func_3_bits[2] && operand_b == '0;
  assign div_ovf  = func_3_bits[2] && !func_3_bits[0] && operand_a == MIN && &operand_b;
  assign fast     = div_zero ? (func_3_bits[1] ? operand_a : '1) : (func_3_bits[1] ? '0 : operand_a);
  // One iteration: shift-add multiply (acc:lo shifts right) or restoring divide (acc:lo shifts left).
  assign sum      = {1'b0, acc} + (lo[0] ? {1'b0, div_b} : '0);
  assign trial    = {acc, lo[XLEN-1]} - {1'b0, div_b};
  assign nxt_acc  = f3[2] ? (trial[XLEN] ? {acc[XLEN-2:0], lo[XLEN-1]} : trial[XLEN-1:0]) : sum[XLEN:1];
  assign nxt_lo   = f3[2] ? {lo[XLEN-2:0], !trial[XLEN]} : {sum[0], lo[XLEN-1:1]};
  assign neg_p    = sign_a ^ sign_b;
  assign prod     = {nxt_acc, nxt_lo};
  assign sprod    = neg_p ? -prod : prod;
  assign quo      = neg_p ? -nxt_lo : nxt_lo;
  assign rem      = sign_a ? -nxt_acc : nxt_acc;
  assign fin      = f3[2] ? (f3[1] ? rem : quo) : (f3[1:0] == 2'b00 ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3        <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      acc       <= '0;
      lo        <= '0;
      div_b     <= '0;
      md_result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (state == S_IDLE) begin
      if (accept) begin
        f3     <= func_3_bits;
        sign_a <= sa;
        sign_b <= sb;
        acc    <= '0;
        lo     <= mag_a;
        div_b  <= mag_b;
        cnt    <= CNT_W'(XLEN);
        if (div_zero || div_ovf) begin
          state     <= S_DONE;
          md_result <= fast;
        end else begin
          state <= S_CALC;
        end
      end
    end else if (state == S_CALC) begin
      acc <= nxt_acc;
      lo  <= nxt_lo;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state     <= S_DONE;
        md_result <= fin;
      end
    end else if (out_ready) begin
      state <= S_IDLE;
    end
  end
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE && !flush;
  assign stall     = !flush && (accept || state == S_CALC || (state == S_DONE && !out_ready));
`else
  logic unused;
  assign md_dec    = 1'b0;
  assign in_ready  = 1'b1;
  assign stall     = 1'b0;
  assign out_valid = 1'b0;
  assign md_result = '0;
  assign unused    = ^{clk, rst_n, in_valid, operand_a, operand_b, flush, out_ready, func_7_bits, {CNT_W{1'b0}}};
`endif
endmodule

// File: tb/tb_alu_exec_controller.sv
// tb_alu_exec_controller: directed checks of the decoder and the multiply/divide sequencer.
module tb_alu_exec_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  func_7_bits = '0;
  logic [2:0]  func_3_bits = '0;
  logic [3:0]  alu_option = '0;
  logic        in_valid = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  alu_operation;
  logic        alu_shift_arith;
  logic        in_ready, stall, out_valid;
  logic [31:0] md_result;
  int total = 0;
  int bad = 0;

  alu_exec_controller #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .func_7_bits(func_7_bits), .func_3_bits(func_3_bits),
    .alu_option(alu_option), .in_valid(in_valid), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .out_ready(out_ready), .alu_operation(alu_operation),
    .alu_shift_arith(alu_shift_arith), .in_ready(in_ready), .stall(stall),
    .out_valid(out_valid), .md_result(md_result)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    total++;
    if ({in_ready, stall, out_valid, md_result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset: got ready=%b stall=%b valid=%b res=%h want 1 0 0 0", in_ready, stall, out_valid, md_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [3:0] opt [12] = '{4'b0110, 4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1100,
                             4'b1111, 4'b0010, 4'b0110, 4'b0110, 4'b0010, 4'b0110};
    logic [6:0] f7 [12]  = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00,
                             7'h00, 7'h20, 7'h00, 7'h01, 7'h01, 7'h01};
    logic [2:0] f3 [12]  = '{3'd0, 3'd5, 3'd5, 3'd7, 3'd5, 3'd2,
                             3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd5};
`ifdef ALU_EXEC_MULDIV_EN
    logic [3:0] exp_op [12] = '{4'b0001, 4'b1110, 4'b1110, 4'b0111, 4'b1000, 4'b0000,
                                4'b0000, 4'b0000, 4'b1001, 4'b1111, 4'b0000, 4'b1111};
`else
    logic [3:0] exp_op [12] = '{4'b0001, 4'b1110, 4'b1110, 4'b0111, 4'b1000, 4'b0000,
                                4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1110};
`endif
    logic       exp_ar [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      alu_option = opt[i];
      func_7_bits = f7[i];
      func_3_bits = f3[i];
      #1;
      total++;
      if ({alu_operation, alu_shift_arith} !== {exp_op[i], exp_ar[i]}) begin
        bad++;
        $display("FAIL decode[%0d]: got op=%b arith=%b want op=%b arith=%b", i, alu_operation, alu_shift_arith, exp_op[i], exp_ar[i]);
      end
    end
    alu_option = 4'b0000;
    func_7_bits = '0;
  endtask

  // Issue one M-op; returns at the first cycle out_valid is seen (or after the bound) with
  // the cycle count since acceptance and the number of stalled cycles before that point.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int stalls);
    @(negedge clk);
    alu_option = 4'b0110;
    func_7_bits = 7'h01;
    func_3_bits = f3;
    operand_a = a;
    operand_b = b;
    in_valid = 1'b1;
    #1;
    cyc = 0;
    stalls = 0;
    while (!out_valid && cyc < 100) begin
      if (stall) stalls++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

`ifdef ALU_EXEC_MULDIV_EN
  task automatic test_mul();
    int cyc, st;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, cyc, st);
    total++;
    if (cyc !== 33 || st !== 33) begin
      bad++;
      $display("FAIL mul_latency: got cycles=%0d stalls=%0d want 33 33", cyc, st);
    end
    total++;
    if (md_result !== 32'hFFFFFFEB) begin
      bad++;
      $display("FAIL mul_result: got %h want ffffffeb", md_result);
    end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, st);
    total++;
    if (md_result !== 32'hFFFFFFFE) begin
      bad++;
      $display("FAIL mulhu: got %h want fffffffe", md_result);
    end
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, st);
    total++;
    if (md_result !== 32'h00000000) begin
      bad++;
      $display("FAIL mulh: got %h want 00000000", md_result);
    end
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, cyc, st);
    total++;
    if (md_result !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL mulhsu: got %h want ffffffff", md_result);
    end
  endtask

  task automatic test_div_fast();
    logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] a  [4] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e  [4] = '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0};
    int cyc, st;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], cyc, st);
      total++;
      if (cyc !== 1 || md_result !== e[i]) begin
        bad++;
        $display("FAIL div_fast[%0d]: got cycles=%0d res=%h want cycles=1 res=%h", i, cyc, md_result, e[i]);
      end
    end
  endtask

  task automatic test_div_hold();
    int cyc, st;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, cyc, st);
    total++;
    if (cyc !== 33 || md_result !== 32'hFFFFFFFD) begin
      bad++;
      $display("FAIL div_signed: got cycles=%0d res=%h want 33 fffffffd", cyc, md_result);
    end
    out_ready = 1'b0;
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, cyc, st);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, stall, md_result} !== {1'b1, 1'b1, 32'hFFFFFFFF}) begin
        bad++;
        $display("FAIL rem_hold[%0d]: got valid=%b stall=%b res=%h want 1 1 ffffffff", i, out_valid, stall, md_result);
      end
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_release: got stall=%b valid=%b want 0 1", stall, out_valid);
    end
    run_op(3'b101, 32'hFFFFFFFF, 32'd16, cyc, st);
    total++;
    if (md_result !== 32'h0FFFFFFF) begin
      bad++;
      $display("FAIL divu: got %h want 0fffffff", md_result);
    end
    run_op(3'b111, 32'hFFFFFFFF, 32'd16, cyc, st);
    total++;
    if (md_result !== 32'd15) begin
      bad++;
      $display("FAIL remu: got %h want 0000000f", md_result);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    @(negedge clk);
    alu_option = 4'b0110;
    func_7_bits = 7'h01;
    func_3_bits = 3'b000;
    operand_a = 32'd5;
    operand_b = 32'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    total++;
    if ({out_valid, stall} !== 2'b00) begin
      bad++;
      $display("FAIL flush_cycle: got valid=%b stall=%b want 0 0", out_valid, stall);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if ({in_ready, stall} !== 2'b10) begin
      bad++;
      $display("FAIL flush_idle: got ready=%b stall=%b want 1 0", in_ready, stall);
    end
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    int cyc, st;
    @(negedge clk);
    alu_option = 4'b0110;
    func_7_bits = 7'h01;
    func_3_bits = 3'b100;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, stall, out_valid, md_result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL async_reset: got ready=%b stall=%b valid=%b res=%h want 1 0 0 0", in_ready, stall, out_valid, md_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b100, 32'd1000, 32'd3, cyc, st);
    total++;
    if (cyc !== 33 || md_result !== 32'd333) begin
      bad++;
      $display("FAIL div_after_reset: got cycles=%0d res=%h want 33 0000014d", cyc, md_result);
    end
  endtask
`else
  task automatic test_disabled();
    @(negedge clk);
    alu_option = 4'b0110;
    func_7_bits = 7'h01;
    func_3_bits = 3'b000;
    operand_a = 32'd7;
    operand_b = 32'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({in_ready, stall, out_valid, md_result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL disabled[%0d]: got ready=%b stall=%b valid=%b res=%h want 1 0 0 0", i, in_ready, stall, out_valid, md_result);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
`ifdef ALU_EXEC_MULDIV_EN
    test_mul();
    test_div_fast();
    test_div_hold();
    test_flush();
    test_async_reset();
`else
    test_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
